// File: rtl/spi_erase_ctrl.sv
// spi_erase_ctrl: SPI NOR flash erase engine.
// Sends WREN, then a sector/subsector/bulk erase command with its address,
// then polls RDSR until WIP clears or the poll budget runs out. All outputs
// are registered; sck is mode 0 (idle low) and runs at sclk/CLK_DIV.
module spi_erase_ctrl #(
  parameter int unsigned CLK_DIV    = 4,
  parameter int unsigned ADDR_BYTES = 3,
  parameter int unsigned CS_GAP     = 8,
  parameter logic [15:0] POLL_MAX   = 16'd50000,
  parameter logic [7:0]  SE_OP      = 8'hD8,
  parameter logic [7:0]  SSE_OP     = 8'h20,
  parameter logic [7:0]  BE_OP      = 8'hC7
) (
  input  logic                    sclk,
  input  logic                    rst,
  input  logic                    start,
  input  logic [1:0]              mode,
  input  logic [8*ADDR_BYTES-1:0] addr,
  output logic                    busy,
  output logic                    done,
  output logic                    err,
  output logic                    cs_n,
  output logic                    sck,
  output logic                    sdi,
  input  logic                    sdo
);

  localparam int AW    = 8 * ADDR_BYTES;
  // Longest frame is opcode + 4 address bytes; frames are left-justified.
  localparam int FR_W  = 40;
  localparam int SH    = FR_W - 8 - AW;
  localparam int BIT_W = 6;
  localparam int PH_W  = $clog2(CLK_DIV);
  localparam int GAP_W = $clog2(CS_GAP);
  localparam int PC_W  = $clog2(int'(POLL_MAX) + 1);

  localparam logic [PH_W-1:0]  PH_HALF  = PH_W'(CLK_DIV / 2);
  localparam logic [PH_W-1:0]  PH_LAST  = PH_W'(CLK_DIV - 1);
  localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(CS_GAP - 1);
  localparam logic [PC_W-1:0]  POLL_LIM = PC_W'(POLL_MAX);
  localparam logic [7:0]       WREN_OP  = 8'h06;
  localparam logic [7:0]       RDSR_OP  = 8'h05;

  typedef enum logic [2:0] {
    S_IDLE, S_WREN, S_GAP1, S_ERASE, S_GAP2, S_POLL, S_GAP3, S_FIN
  } state_t;

  state_t            state;
  logic [1:0]        mode_q;
  logic [AW-1:0]     addr_q;
  logic [FR_W-1:0]   shreg;
  logic [BIT_W-1:0]  nbits;
  logic [BIT_W-1:0]  bit_idx;
  logic [PH_W-1:0]   phase;
  logic [GAP_W-1:0]  gap_cnt;
  logic [PC_W-1:0]   poll_cnt;
  logic              rx_bit;

  logic [FR_W-1:0]   ld_frame;
  logic [BIT_W-1:0]  ld_bits;
  logic [PH_W-1:0]   phase_nx;
  logic [PC_W-1:0]   poll_nx;
  logic              stat_b0;

  // Next frame to load: WREN from IDLE, erase command after GAP1, RDSR otherwise.
  always_comb begin
    ld_frame = {RDSR_OP, 32'h0};
    ld_bits  = BIT_W'(16);
    if (state == S_IDLE) begin
      ld_frame = {WREN_OP, 32'h0};
      ld_bits  = BIT_W'(8);
    end else if (state == S_GAP1) begin
      if (mode_q == 2'd0) begin
        ld_frame = FR_W'({SE_OP, addr_q}) << SH;
        ld_bits  = BIT_W'(8 + AW);
      end else if (mode_q == 2'd1) begin
        ld_frame = FR_W'({SSE_OP, addr_q}) << SH;
        ld_bits  = BIT_W'(8 + AW);
      end else begin
        ld_frame = {BE_OP, 32'h0};
        ld_bits  = BIT_W'(8);
      end
    end
    phase_nx = phase + 1'b1;
    poll_nx  = poll_cnt + 1'b1;
    // Status bit0 is the last bit read; with CLK_DIV=2 it is sampled in the
    // same cycle the frame ends, so take it straight from sdo.
    stat_b0  = (phase == PH_HALF) ? sdo : rx_bit;
  end

  // Sequencer and SPI bit engine with registered outputs.
  always_ff @(posedge sclk) begin
    if (rst) begin
      state    <= S_IDLE;
      cs_n     <= 1'b1;
      sck      <= 1'b0;
      sdi      <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
      err      <= 1'b0;
      phase    <= '0;
      bit_idx  <= '0;
      nbits    <= '0;
      gap_cnt  <= '0;
      poll_cnt <= '0;
    end else begin
      done <= 1'b0;
      err  <= 1'b0;
      unique case (state)
        S_IDLE: begin
          if (start) begin
            if (mode == 2'd3) begin
              err <= 1'b1;
            end else begin
              mode_q   <= mode;
              addr_q   <= addr;
              busy     <= 1'b1;
              poll_cnt <= '0;
              cs_n     <= 1'b0;
              sck      <= 1'b0;
              phase    <= '0;
              bit_idx  <= '0;
              shreg    <= ld_frame;
              sdi      <= ld_frame[FR_W-1];
              nbits    <= ld_bits;
              state    <= S_WREN;
            end
          end
        end
        S_GAP1, S_GAP2, S_GAP3: begin
          if (gap_cnt == GAP_LAST) begin
            gap_cnt <= '0;
            cs_n    <= 1'b0;
            sck     <= 1'b0;
            phase   <= '0;
            bit_idx <= '0;
            shreg   <= ld_frame;
            sdi     <= ld_frame[FR_W-1];
            nbits   <= ld_bits;
            state   <= (state == S_GAP1) ? S_ERASE : S_POLL;
          end else begin
            gap_cnt <= gap_cnt + 1'b1;
          end
        end
        S_WREN, S_ERASE, S_POLL: begin
          if (phase == PH_HALF) rx_bit <= sdo;
          if (phase == PH_LAST) begin
            phase <= '0;
            sck   <= 1'b0;
            if (bit_idx == nbits - 1'b1) begin
              cs_n    <= 1'b1;
              sdi     <= 1'b0;
              gap_cnt <= '0;
              if (state == S_WREN) begin
                state <= S_GAP1;
              end else if (state == S_ERASE) begin
                state <= S_GAP2;
              end else begin
                poll_cnt <= poll_nx;
                if (!stat_b0) begin
                  state <= S_FIN;
                end else if (poll_nx == POLL_LIM) begin
                  err   <= 1'b1;
                  busy  <= 1'b0;
                  state <= S_IDLE;
                end else begin
                  state <= S_GAP3;
                end
              end
            end else begin
              bit_idx <= bit_idx + 1'b1;
              shreg   <= {shreg[FR_W-2:0], 1'b0};
              sdi     <= shreg[FR_W-2];
            end
          end else begin
            phase <= phase_nx;
            sck   <= (phase_nx >= PH_HALF);
          end
        end
        S_FIN: begin
          done  <= 1'b1;
          busy  <= 1'b0;
          state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_spi_erase_ctrl.sv
// tb_spi_erase_ctrl: two configurations of spi_erase_ctrl driven by directed
// and randomized erase requests; a flash model answers RDSR and a frame
// recorder is compared against the expected command sequence.
module tb_spi_erase_ctrl;

  logic        sclk = 1'b0;
  logic        rst;
  logic        start_a, start_b;
  logic [1:0]  mode_a, mode_b;
  logic [23:0] addr_a;
  logic [31:0] addr_b;
  logic [1:0]  busy, done, err, cs_n, sck, sdi;
  logic [1:0]  sdo = 2'b00;

  int nvec = 0;
  int nmis = 0;

  always #5 sclk = ~sclk;

  spi_erase_ctrl u_a (
    .sclk(sclk), .rst(rst), .start(start_a), .mode(mode_a), .addr(addr_a),
    .busy(busy[0]), .done(done[0]), .err(err[0]), .cs_n(cs_n[0]),
    .sck(sck[0]), .sdi(sdi[0]), .sdo(sdo[0])
  );

  spi_erase_ctrl #(.CLK_DIV(8), .ADDR_BYTES(4), .CS_GAP(3), .POLL_MAX(16'd5)) u_b (
    .sclk(sclk), .rst(rst), .start(start_b), .mode(mode_b), .addr(addr_b),
    .busy(busy[1]), .done(done[1]), .err(err[1]), .cs_n(cs_n[1]),
    .sck(sck[1]), .sdi(sdi[1]), .sdo(sdo[1])
  );

  // Flash model configuration for the current request, per instance.
  int         busy_polls [2];
  logic [7:0] busy_st    [2];
  logic [7:0] ready_st   [2];
  int         rd_base    [2];

  // Recorded frames.
  logic [39:0] fr_bits [2][256];
  int fr_rise [2][256];
  int fr_low  [2][256];
  int fr_high [2][256];
  int fr_gap  [2][256];
  int fcnt[2], rd_total[2], n_done[2], n_err[2];
  int bad_sck[2], bad_busy[2], bad_fall[2], bad_both[2];

  logic [39:0] cur_bits [2];
  int          cur_rise [2], cur_low [2], cur_high [2], cur_gap [2], hi_run [2];
  logic [7:0]  cur_stat [2];
  logic [1:0]  prev_cs = 2'b11, prev_sck = 2'b00, prev_busy = 2'b00;
  logic        prev_rst = 1'b1;

  // Bus monitor and RDSR responder, sampled on the inactive edge.
  always @(negedge sclk) begin
    for (int k = 0; k < 2; k++) begin
      if (!cs_n[k]) begin
        if (prev_cs[k]) begin
          cur_bits[k] = '0;
          cur_rise[k] = 0;
          cur_low[k]  = 0;
          cur_high[k] = 0;
          cur_gap[k]  = hi_run[k];
          cur_stat[k] = ((rd_total[k] - rd_base[k]) < busy_polls[k]) ? busy_st[k] : ready_st[k];
        end
        cur_low[k]++;
        if (sck[k]) cur_high[k]++;
        if (sck[k] && !prev_sck[k]) begin
          cur_bits[k] = {cur_bits[k][38:0], sdi[k]};
          cur_rise[k]++;
        end
        // Flash shifts status out on falling sck, MSB first.
        if (!sck[k] && prev_sck[k] && cur_rise[k] >= 8 && cur_rise[k] < 16)
          sdo[k] = cur_stat[k][15 - cur_rise[k]];
        if (!busy[k]) bad_busy[k]++;
      end else begin
        if (!prev_cs[k]) begin
          if (fcnt[k] < 256) begin
            fr_bits[k][fcnt[k]] = cur_bits[k];
            fr_rise[k][fcnt[k]] = cur_rise[k];
            fr_low[k][fcnt[k]]  = cur_low[k];
            fr_high[k][fcnt[k]] = cur_high[k];
            fr_gap[k][fcnt[k]]  = cur_gap[k];
          end
          fcnt[k]++;
          if (cur_rise[k] == 16 && cur_bits[k][15:8] == 8'h05) rd_total[k]++;
          hi_run[k] = 0;
          sdo[k] = 1'b0;
        end
        hi_run[k]++;
        if (sck[k]) bad_sck[k]++;
      end
      if (done[k] && err[k]) bad_both[k]++;
      if (done[k]) n_done[k]++;
      if (err[k]) n_err[k]++;
      if (prev_busy[k] && !busy[k] && !done[k] && !err[k] && !prev_rst) bad_fall[k]++;
      if (done[k] && !prev_busy[k]) bad_fall[k]++;
      prev_cs[k]   = cs_n[k];
      prev_sck[k]  = sck[k];
      prev_busy[k] = busy[k];
    end
    prev_rst = rst;
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    nvec++;
    assert (obs === exp) else begin
      nmis++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input int k, input logic s, input int m, input logic [31:0] a);
    if (k == 0) begin
      start_a = s; mode_a = 2'(m); addr_a = a[23:0];
    end else begin
      start_b = s; mode_b = 2'(m); addr_b = a;
    end
  endtask

  // Expected command sequence for one request, from the flash protocol rules.
  task automatic check_op(input int k, input int md, input logic [31:0] ad, input int bp,
                          input int fb, input int db, input int eb);
    int ab, cd, gp, pm, np, nf, en, j, g;
    logic [39:0] ev;
    logic [7:0]  op;
    logic [31:0] mask;
    ab = (k != 0) ? 4 : 3;
    cd = (k != 0) ? 8 : 4;
    gp = (k != 0) ? 3 : 8;
    pm = (k != 0) ? 5 : 50000;
    mask = (ab == 3) ? 32'h00FF_FFFF : 32'hFFFF_FFFF;
    np = (bp < pm) ? bp + 1 : pm;
    nf = 2 + np;
    chk($sformatf("k%0d_frame_count", k), 64'(fcnt[k] - fb), 64'(nf));
    for (int i = 0; i < nf; i++) begin
      j = fb + i;
      if (j >= 256) break;
      if (i == 0) begin
        ev = 40'h06; en = 8;
      end else if (i == 1) begin
        op = (md == 0) ? 8'hD8 : (md == 1) ? 8'h20 : 8'hC7;
        if (md == 2) begin
          ev = {32'h0, op}; en = 8;
        end else begin
          ev = ({32'h0, op} << (8 * ab)) | {8'h0, ad & mask};
          en = 8 + 8 * ab;
        end
      end else begin
        ev = 40'h0500; en = 16;
      end
      chk($sformatf("k%0d_frame%0d_bits", k, i),
          {8'(fr_rise[k][j]), fr_bits[k][j]}, {8'(en), ev});
      g = (i == 0) ? 0 : fr_gap[k][j];
      chk($sformatf("k%0d_frame%0d_timing", k, i),
          {16'(fr_low[k][j]), 16'(fr_high[k][j]), 16'(g)},
          {16'(en * cd), 16'(en * cd / 2), 16'((i == 0) ? 0 : gp)});
    end
    chk($sformatf("k%0d_done_pulses", k), 64'(n_done[k] - db), 64'(bp < pm));
    chk($sformatf("k%0d_err_pulses", k), 64'(n_err[k] - eb), 64'(bp >= pm));
  endtask

  task automatic run_op(input int k, input int md, input logic [31:0] ad, input int bp,
                        input logic [7:0] bs, input logic [7:0] rs, input bit mid);
    int fb, db, eb;
    bit fin;
    fb = fcnt[k]; db = n_done[k]; eb = n_err[k];
    rd_base[k] = rd_total[k];
    busy_polls[k] = bp;
    busy_st[k] = bs | 8'h01;
    ready_st[k] = rs & 8'hFE;
    drive(k, 1'b1, md, ad);
    @(posedge sclk); #1;
    drive(k, 1'b0, int'($urandom_range(0, 3)), $urandom);
    chk($sformatf("k%0d_busy_up", k), 64'(busy[k]), 64'd1);
    fin = 0;
    for (int i = 0; i < 30000 && !fin; i++) begin
      @(posedge sclk); #1;
      if (mid && i == 60) drive(k, 1'b1, 2, $urandom);
      if (mid && i == 61) drive(k, 1'b0, 2, $urandom);
      if (done[k] || err[k]) begin
        fin = 1;
        chk($sformatf("k%0d_busy_at_end", k), 64'(busy[k]), 64'd0);
      end
    end
    chk($sformatf("k%0d_completed", k), 64'(fin), 64'd1);
    @(posedge sclk); #1;
    chk($sformatf("k%0d_pulse_one_cycle", k), 64'({done[k], err[k]}), 64'd0);
    repeat (4) @(posedge sclk);
    #1;
    check_op(k, md, ad, bp, fb, db, eb);
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int fb, db, eb, k, md, bp;
    bit seen;
    rst = 1'b1;
    drive(0, 1'b0, 0, 32'h0);
    drive(1, 1'b0, 0, 32'h0);
    for (int i = 0; i < 2; i++) begin
      busy_polls[i] = 0; busy_st[i] = 8'h01; ready_st[i] = 8'h00; rd_base[i] = 0;
    end
    repeat (5) @(posedge sclk);
    #1;
    for (int i = 0; i < 2; i++) begin
      chk($sformatf("k%0d_rst_cs_n", i), 64'(cs_n[i]), 64'd1);
      chk($sformatf("k%0d_rst_sck", i),  64'(sck[i]),  64'd0);
      chk($sformatf("k%0d_rst_sdi", i),  64'(sdi[i]),  64'd0);
      chk($sformatf("k%0d_rst_busy", i), 64'(busy[i]), 64'd0);
      chk($sformatf("k%0d_rst_done", i), 64'(done[i]), 64'd0);
      chk($sformatf("k%0d_rst_err", i),  64'(err[i]),  64'd0);
    end
    rst = 1'b0;
    @(posedge sclk); #1;

    // Sector erase with three busy polls, then bulk erase ready at once.
    run_op(0, 0, 32'h0040_0000, 3, 8'h01, 8'h00, 0);
    run_op(0, 2, $urandom, 0, 8'h01, 8'h00, 0);
    // 4-byte subsector erase at sck = sclk/8.
    run_op(1, 1, 32'h0102_0304, int'($urandom_range(0, 3)), 8'($urandom), 8'($urandom), 0);
    // Status stuck at FF: poll budget of 5 runs out.
    run_op(1, 0, $urandom, 100, 8'hFF, 8'h00, 0);

    // Illegal mode: immediate err, no frame, busy never set.
    fb = fcnt[0]; eb = n_err[0];
    drive(0, 1'b1, 3, $urandom);
    @(posedge sclk); #1;
    drive(0, 1'b0, 0, 32'h0);
    chk("mode3_err", 64'(err[0]), 64'd1);
    chk("mode3_busy", 64'(busy[0]), 64'd0);
    chk("mode3_cs_n", 64'(cs_n[0]), 64'd1);
    @(posedge sclk); #1;
    chk("mode3_err_clear", 64'(err[0]), 64'd0);
    repeat (20) @(posedge sclk);
    #1;
    chk("mode3_no_frame", 64'(fcnt[0] - fb), 64'd0);
    chk("mode3_err_count", 64'(n_err[0] - eb), 64'd1);

    // Second start while busy must not disturb the sequence.
    run_op(0, 0, $urandom, int'($urandom_range(0, 2)), 8'($urandom), 8'($urandom), 1);

    // Randomized requests on both configurations.
    for (int n = 0; n < 6; n++) begin
      k  = int'($urandom_range(0, 1));
      md = int'($urandom_range(0, 2));
      bp = (k != 0) ? int'($urandom_range(0, 7)) : int'($urandom_range(0, 3));
      run_op(k, md, $urandom, bp, 8'($urandom), 8'($urandom), 0);
    end

    // Reset during the first address byte of the erase frame.
    fb = fcnt[0]; db = n_done[0]; eb = n_err[0];
    rd_base[0] = rd_total[0]; busy_polls[0] = 0;
    drive(0, 1'b1, 0, 32'h00AB_CDEF);
    @(posedge sclk); #1;
    drive(0, 1'b0, 0, 32'h0);
    seen = 0;
    for (int i = 0; i < 2000; i++) begin
      @(posedge sclk); #1;
      if (fcnt[0] == fb + 1 && !cs_n[0]) begin
        seen = 1;
        break;
      end
    end
    chk("rst_erase_frame_seen", 64'(seen), 64'd1);
    repeat (37) @(posedge sclk);
    #1;
    rst = 1'b1;
    @(posedge sclk); #1;
    chk("midrst_cs_n", 64'(cs_n[0]), 64'd1);
    chk("midrst_sck",  64'(sck[0]),  64'd0);
    chk("midrst_sdi",  64'(sdi[0]),  64'd0);
    chk("midrst_busy", 64'(busy[0]), 64'd0);
    chk("midrst_done", 64'(done[0]), 64'd0);
    chk("midrst_err",  64'(err[0]),  64'd0);
    rst = 1'b0;
    repeat (30) @(posedge sclk);
    #1;
    chk("midrst_no_pulse", 64'({16'(n_done[0] - db), 16'(n_err[0] - eb)}), 64'd0);
    run_op(0, 0, 32'h0012_3456, 1, 8'h03, 8'h00, 0);

    for (int i = 0; i < 2; i++) begin
      chk($sformatf("k%0d_sck_low_when_idle", i), 64'(bad_sck[i]), 64'd0);
      chk($sformatf("k%0d_busy_over_frames", i), 64'(bad_busy[i]), 64'd0);
      chk($sformatf("k%0d_busy_fall_with_pulse", i), 64'(bad_fall[i]), 64'd0);
      chk($sformatf("k%0d_done_err_exclusive", i), 64'(bad_both[i]), 64'd0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
    $finish;
  end

endmodule
